msi_snoop_arbiter: RTL
======================

MSI_SNOOP_ARBITER -- requirements
Module: msi_snoop_arbiter

Interface
REQ-001 Parameter: WDOG_LIM, default 16, memory-wait cycles before a watchdog abort (only used when MSI_ARB_WDOG_EN is defined).
REQ-002 Port: clk  input  1  system clock, all state updates on the rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: req0 / req1  input  1 each  miss or upgrade request from CPU0 / CPU1, held high until doneX or errX.
REQ-005 Port: rw0 / rw1  input  1 each  request type, 1 = write (BusRdX/upgrade), 0 = read (BusRd).
REQ-006 Port: addr0 / addr1  input  11 each  line address, same format as the cache addr port (tag[10:6], index[5:0]).
REQ-007 Port: gnt0 / gnt1  output  1 each  one-cycle grant pulse.
REQ-008 Port: done0 / done1  output  1 each  one-cycle completion pulse.
REQ-009 Port: err0 / err1  output  1 each  one-cycle watchdog abort pulse.
REQ-010 Port: snp_sel  output  1  index of the cache being snooped, the non-owner.
REQ-011 Port: snp_search  output  1  drives cpu_search of the snooped cache.
REQ-012 Port: snp_boci  output  11  drives BOCI of the snooped cache, equal to the latched owner address.
REQ-013 Port: snp_found  input  1  cpu_search_found from the snooped cache.
REQ-014 Port: snp_inval  output  1  drives invalidate_from_other_cpu of the snooped cache.
REQ-015 Port: shared  output  1  the line is sourced from the snooped cache's other_proc_data_line_wire.
REQ-016 Port: mem_re  output  1  memory line-fill request.
REQ-017 Port: mem_rdy  input  1  memory fill data valid.
REQ-018 Port: busy  output  1  high in every state except IDLE.

Function
REQ-019 All outputs SHALL be registered, decoded from the state and the latched owner, owner address and type.
REQ-020 FSM states SHALL be IDLE, GRANT, SNOOP, SUPPLY, MEM, INVAL, DONE.
REQ-021 IDLE: if any reqX is high at the edge, the block SHALL latch the winner's addr and rw, set owner, and go to GRANT; otherwise it SHALL stay in IDLE.
REQ-022 Arbitration SHALL be round-robin using a last-granted pointer: with both requests high, the non-last-granted CPU wins; with a single request, that CPU wins.
REQ-023 GRANT: gntX=1 for the owner for one cycle, then SNOOP.
REQ-024 SNOOP: snp_search=1 and snp_boci=owner address for one cycle; snp_found is sampled at the edge that ends SNOOP.
REQ-025 Transition out of SNOOP: found -> SUPPLY; not found -> MEM.
REQ-026 SUPPLY: shared=1 for one cycle; then INVAL if the request is a write, else DONE.
REQ-027 MEM: mem_re=1 held until mem_rdy is sampled high; then INVAL if the request is a write, else DONE.
REQ-028 INVAL: snp_inval=1 for one cycle, then DONE; writes always invalidate, because a SHARED copy is not reported by snp_found.
REQ-029 DONE: doneX=1 for the owner for one cycle, the last-granted pointer is updated to the owner, then IDLE.
REQ-030 The minimum spacing between transactions SHALL be one IDLE cycle; requests are never sampled in DONE.
REQ-031 Latency from request edge N: read hit-in-other gives done at N+4; write hit-in-other gives N+5; read miss with mem_rdy in the first MEM cycle gives N+4; write miss gives N+5.
REQ-032 Deassertion of reqX or changes to addrX/rwX after GRANT SHALL be ignored; the latched transaction completes.
REQ-033 Equal addresses from both CPUs SHALL be serialized with no special handling.
REQ-034 At most one of gnt0/gnt1, done0/done1, err0/err1 SHALL ever be high.

Reset
REQ-035 On rst high, asynchronously: state=IDLE, owner=0, latched address/type=0, last-granted pointer=1 (CPU0 wins first), all outputs 0.
REQ-036 Reset mid-transaction SHALL abort with no done or err pulse; the first edge after rst falls SHALL evaluate IDLE.

Configuration
REQ-037 With macro MSI_ARB_WDOG_EN defined: a counter SHALL clear on MEM entry and increment each MEM cycle without mem_rdy.
REQ-038 Watchdog abort: when the counter reaches WDOG_LIM, the block SHALL drop mem_re, pulse errX for the owner for one cycle, update the pointer, and go to IDLE, skipping INVAL and DONE.
REQ-039 Without MSI_ARB_WDOG_EN: no counter; MEM waits indefinitely; err0/err1 are tied to 0.

Verification
REQ-040 req0=1, rw0=0, addr0=11'h155, snp_found=1 -> gnt0 at N+1, snp_search with snp_boci=11'h155 and snp_sel=1 at N+2, shared at N+3, done0 at N+4, snp_inval never high.
REQ-041 req1=1, rw1=1, addr1=11'h07F, snp_found=0, mem_rdy high 3 cycles into MEM -> mem_re for 3 cycles, then snp_inval one cycle with snp_sel=0, then done1.
REQ-042 req0 and req1 both high from reset, held continuously -> grant order CPU0, CPU1, CPU0, CPU1; never two grants in one cycle.
REQ-043 rst asserted during MEM -> all outputs 0 immediately, no done/err pulse; after release, a pending req1 is granted at the second edge.
REQ-044 MSI_ARB_WDOG_EN defined, WDOG_LIM=16, mem_rdy held 0 -> mem_re for 16 cycles, then err0 pulse, busy=0, no done0, no snp_inval.
REQ-045 Without the macro, mem_rdy held 0 for 100 cycles -> mem_re stays 1 and err0 stays 0; mem_rdy=1 -> done0 follows.

Source files
------------

// File: rtl/msi_snoop_arbiter.sv
// Snooping bus arbiter for two MSI caches: round-robin grant, snoop of the non-owner,
// cache-to-cache supply or memory fill, write invalidate. Optional watchdog: MSI_ARB_WDOG_EN.
module msi_snoop_arbiter #(
  parameter int WDOG_LIM = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        rw0,
  input  logic        rw1,
  input  logic [10:0] addr0,
  input  logic [10:0] addr1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic        snp_sel,
  output logic        snp_search,
  output logic [10:0] snp_boci,
  input  logic        snp_found,
  output logic        snp_inval,
  output logic        shared,
  output logic        mem_re,
  input  logic        mem_rdy,
  output logic        busy,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GRANT  = 3'd1,
    S_SNOOP  = 3'd2,
    S_SUPPLY = 3'd3,
    S_MEM    = 3'd4,
    S_INVAL  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_owner;
  logic        w_owner;
  logic [10:0] r_addr;
  logic [10:0] w_addr;
  logic        r_rw;
  logic        w_rw;
  logic        r_last;
  logic        w_last;
  logic        w_abort;

  logic        r_gnt0, r_gnt1, r_done0, r_done1;
  logic        r_snp_sel, r_snp_search, r_snp_inval, r_shared, r_mem_re, r_busy;
  logic [10:0] r_snp_boci;

`ifdef MSI_ARB_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_LIM + 1);
  logic [WDOG_W-1:0] r_wdog;
  logic              r_err0, r_err1;

  // The abort fires on the MEM cycle whose miss would bring the count to WDOG_LIM.
  assign w_abort = (r_state == S_MEM) && !mem_rdy && (r_wdog == WDOG_W'(WDOG_LIM - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog <= '0;
      r_err0 <= 1'b0;
      r_err1 <= 1'b0;
    end else begin
      if (r_state != S_MEM) r_wdog <= '0;
      else if (!mem_rdy)    r_wdog <= r_wdog + WDOG_W'(1);
      r_err0 <= w_abort && !r_owner;
      r_err1 <= w_abort && r_owner;
    end
  end

  assign err0 = r_err0;
  assign err1 = r_err1;
`else
  logic w_unused_wdog_lim;
  assign w_unused_wdog_lim = ^WDOG_LIM;
  assign w_abort = 1'b0;
  assign err0    = 1'b0;
  assign err1    = 1'b0;
`endif

  always_comb begin
    w_next  = r_state;
    w_owner = r_owner;
    w_addr  = r_addr;
    w_rw    = r_rw;
    w_last  = r_last;
    case (r_state)
      S_IDLE: begin
        if (req0 || req1) begin
          w_next = S_GRANT;
          // CPU0 wins when alone or when CPU1 was the last one served.
          if (req0 && (!req1 || r_last)) begin
            w_owner = 1'b0;
            w_addr  = addr0;
            w_rw    = rw0;
          end else begin
            w_owner = 1'b1;
            w_addr  = addr1;
            w_rw    = rw1;
          end
        end
      end
      S_GRANT:  w_next = S_SNOOP;
      S_SNOOP:  w_next = snp_found ? S_SUPPLY : S_MEM;
      S_SUPPLY: w_next = r_rw ? S_INVAL : S_DONE;
      S_MEM: begin
        if (w_abort) begin
          w_next = S_IDLE;
          w_last = r_owner;
        end else if (mem_rdy) begin
          w_next = r_rw ? S_INVAL : S_DONE;
        end
      end
      S_INVAL: w_next = S_DONE;
      S_DONE: begin
        w_next = S_IDLE;
        w_last = r_owner;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they line up with the state they decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_addr       <= '0;
      r_rw         <= 1'b0;
      r_last       <= 1'b1;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
      r_snp_sel    <= 1'b0;
      r_snp_search <= 1'b0;
      r_snp_boci   <= '0;
      r_snp_inval  <= 1'b0;
      r_shared     <= 1'b0;
      r_mem_re     <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_owner      <= w_owner;
      r_addr       <= w_addr;
      r_rw         <= w_rw;
      r_last       <= w_last;
      r_gnt0       <= (w_next == S_GRANT) && !w_owner;
      r_gnt1       <= (w_next == S_GRANT) && w_owner;
      r_done0      <= (w_next == S_DONE) && !w_owner;
      r_done1      <= (w_next == S_DONE) && w_owner;
      r_snp_sel    <= (w_next != S_IDLE) && !w_owner;
      r_snp_search <= (w_next == S_SNOOP);
      r_snp_boci   <= (w_next != S_IDLE) ? w_addr : 11'd0;
      r_snp_inval  <= (w_next == S_INVAL);
      r_shared     <= (w_next == S_SUPPLY);
      r_mem_re     <= (w_next == S_MEM);
      r_busy       <= (w_next != S_IDLE);
    end
  end

  assign gnt0        = r_gnt0;
  assign gnt1        = r_gnt1;
  assign done0       = r_done0;
  assign done1       = r_done1;
  assign snp_sel     = r_snp_sel;
  assign snp_search  = r_snp_search;
  assign snp_boci    = r_snp_boci;
  assign snp_inval   = r_snp_inval;
  assign shared      = r_shared;
  assign mem_re      = r_mem_re;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule
